// File: rtl/usb_pkg.sv
// USB bulk IN scheduling constants and shared types.
// PID encodings, max-packet sizes and scheduler state enum.
package usb_pkg;

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  localparam logic [9:0] MPS_HS = 10'd512;
  localparam logic [9:0] MPS_FS = 10'd64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WAIT
  } sched_state_e;

  function automatic logic [3:0] data_pid(input logic tgl);
    return tgl ? PID_DATA1 : PID_DATA0;
  endfunction

endpackage

// File: rtl/bulk_in_sched.sv
// Bulk IN scheduler: answers IN tokens with NAK or DATAx,
// streams one max-packet from the addressed endpoint FIFO.
module bulk_in_sched
  import usb_pkg::*;
#(
  parameter int NUM_EP  = 2,
  parameter int EP_BASE = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  hs_mode_i,
  input  logic                  tok_valid_i,
  input  logic [3:0]            tok_ep_i,
  input  logic                  ack_i,
  input  logic                  timeout_i,
  input  logic [NUM_EP-1:0]     clr_toggle_i,
  input  logic [NUM_EP-1:0]     ep_has_data_i,
  output logic [NUM_EP-1:0]     ep_xfer_o,
  input  logic [NUM_EP-1:0]     ep_tvalid_i,
  input  logic [NUM_EP-1:0]     ep_tlast_i,
  input  logic [8*NUM_EP-1:0]   ep_tdata_i,
  output logic [NUM_EP-1:0]     ep_tready_o,
  output logic                  hdr_valid_o,
  input  logic                  hdr_ready_i,
  output logic [3:0]            hdr_pid_o,
  output logic                  hdr_zlp_o,
  output logic                  tx_tvalid_o,
  input  logic                  tx_tready_i,
  output logic                  tx_tlast_o,
  output logic [7:0]            tx_tdata_o
);

  localparam int SW = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;

  sched_state_e      state_q;
  logic [SW-1:0]     sel_q;
  logic [9:0]        cnt_q;
  logic [9:0]        last_q;
  logic              nak_q;
  logic              zlp_hdr_q;
  logic              hdr_valid_q;
  logic [3:0]        pid_q;
  logic [NUM_EP-1:0] toggle_q;
  logic [NUM_EP-1:0] zlp_q;
  logic [NUM_EP-1:0] xfer_q;

  logic [3:0]    tok_off;
  logic          tok_hit;
  logic [SW-1:0] tok_sel;
  logic          elig;

  assign tok_off = tok_ep_i - 4'(EP_BASE);
  assign tok_hit = (tok_ep_i >= 4'(EP_BASE)) &&
                   (tok_off < 4'(NUM_EP));
  assign tok_sel = tok_off[SW-1:0];
  assign elig    = ep_has_data_i[tok_sel] | zlp_q[tok_sel];

  logic in_data;
  logic at_max;
  logic src_last;
  logic beat;

  assign in_data     = (state_q == S_DATA);
  assign at_max      = (cnt_q == last_q);
  assign src_last    = ep_tlast_i[sel_q];
  assign tx_tvalid_o = in_data & ep_tvalid_i[sel_q];
  assign tx_tlast_o  = in_data & (src_last | at_max);
  assign tx_tdata_o  = in_data ? ep_tdata_i[8*sel_q +: 8] : 8'h00;
  assign beat        = tx_tvalid_o & tx_tready_i;

  always_comb begin
    ep_tready_o = '0;
    if (in_data) ep_tready_o[sel_q] = tx_tready_i;
  end

  assign hdr_valid_o = hdr_valid_q;
  assign hdr_pid_o   = pid_q;
  assign hdr_zlp_o   = zlp_hdr_q;
  assign ep_xfer_o   = xfer_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      last_q      <= '0;
      nak_q       <= 1'b0;
      zlp_hdr_q   <= 1'b0;
      hdr_valid_q <= 1'b0;
      pid_q       <= '0;
      toggle_q    <= '0;
      zlp_q       <= '0;
      xfer_q      <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (tok_valid_i && tok_hit) begin
            sel_q       <= tok_sel;
            cnt_q       <= '0;
            last_q      <= (hs_mode_i ? MPS_HS : MPS_FS) - 10'd1;
            hdr_valid_q <= 1'b1;
            nak_q       <= ~elig;
            state_q     <= S_HDR;
            if (elig) begin
              pid_q           <= data_pid(toggle_q[tok_sel]);
              zlp_hdr_q       <= zlp_q[tok_sel];
              xfer_q[tok_sel] <= 1'b1;
            end else begin
              pid_q     <= PID_NAK;
              zlp_hdr_q <= 1'b0;
            end
          end
        end
        S_HDR: begin
          if (hdr_ready_i) begin
            hdr_valid_q <= 1'b0;
            pid_q       <= '0;
            zlp_hdr_q   <= 1'b0;
            if (nak_q) begin
              state_q <= S_IDLE;
            end else if (zlp_hdr_q) begin
              // the ZLP itself terminates the transfer
              zlp_q[sel_q] <= 1'b0;
              state_q      <= S_WAIT;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (beat) begin
            cnt_q <= cnt_q + 10'd1;
            if (tx_tlast_o) begin
              zlp_q[sel_q] <= src_last & at_max;
              state_q      <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (ack_i) begin
            toggle_q[sel_q] <= ~toggle_q[sel_q];
            xfer_q          <= '0;
            state_q         <= S_IDLE;
          end else if (timeout_i) begin
            xfer_q  <= '0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // a host-side clear overrides a same-cycle ACK flip
      for (int i = 0; i < NUM_EP; i++) begin
        if (clr_toggle_i[i]) begin
          toggle_q[i] <= 1'b0;
          zlp_q[i]    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bulk_in_sched.sv
// Self-checking bench for bulk_in_sched: randomized endpoint
// sources and sink against a message-level packetizing model.
module tb_bulk_in_sched;

  localparam int NUM_EP  = 2;
  localparam int EP_BASE = 1;

  logic                clock;
  logic                reset_n;
  logic                hs_mode_i;
  logic                tok_valid_i;
  logic [3:0]          tok_ep_i;
  logic                ack_i;
  logic                timeout_i;
  logic [NUM_EP-1:0]   clr_toggle_i;
  logic [NUM_EP-1:0]   ep_has_data_i;
  logic [NUM_EP-1:0]   ep_xfer_o;
  logic [NUM_EP-1:0]   ep_tvalid_i;
  logic [NUM_EP-1:0]   ep_tlast_i;
  logic [8*NUM_EP-1:0] ep_tdata_i;
  logic [NUM_EP-1:0]   ep_tready_o;
  logic                hdr_valid_o;
  logic                hdr_ready_i;
  logic [3:0]          hdr_pid_o;
  logic                hdr_zlp_o;
  logic                tx_tvalid_o;
  logic                tx_tready_i;
  logic                tx_tlast_o;
  logic [7:0]          tx_tdata_o;

  bulk_in_sched #(.NUM_EP(NUM_EP), .EP_BASE(EP_BASE)) dut (
    .clock(clock), .reset_n(reset_n), .hs_mode_i(hs_mode_i),
    .tok_valid_i(tok_valid_i), .tok_ep_i(tok_ep_i),
    .ack_i(ack_i), .timeout_i(timeout_i),
    .clr_toggle_i(clr_toggle_i), .ep_has_data_i(ep_has_data_i),
    .ep_xfer_o(ep_xfer_o), .ep_tvalid_i(ep_tvalid_i),
    .ep_tlast_i(ep_tlast_i), .ep_tdata_i(ep_tdata_i),
    .ep_tready_o(ep_tready_o), .hdr_valid_o(hdr_valid_o),
    .hdr_ready_i(hdr_ready_i), .hdr_pid_o(hdr_pid_o),
    .hdr_zlp_o(hdr_zlp_o), .tx_tvalid_o(tx_tvalid_o),
    .tx_tready_i(tx_tready_i), .tx_tlast_o(tx_tlast_o),
    .tx_tdata_o(tx_tdata_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk;
  int n_fail;

  logic [8:0] src_q[NUM_EP][$];
  logic [8:0] mq[NUM_EP][$];
  logic [8:0] cap_q[$];
  logic [8:0] exp_q[$];
  bit         got_last;
  bit         m_tgl[NUM_EP];
  bit         m_zlp[NUM_EP];

  // endpoint sources and transmitter sink
  always @(negedge clock) begin
    for (int i = 0; i < NUM_EP; i++) begin
      ep_has_data_i[i] = src_q[i].size() > 0;
      ep_tvalid_i[i] = ep_has_data_i[i] && ($urandom_range(3) != 0);
      ep_tlast_i[i] = ep_has_data_i[i] ? src_q[i][0][8] : 1'b0;
      ep_tdata_i[8*i +: 8] = ep_has_data_i[i] ? src_q[i][0][7:0] : 8'h00;
    end
    tx_tready_i = $urandom_range(3) != 0;
    #4;
    for (int i = 0; i < NUM_EP; i++)
      if (ep_tvalid_i[i] && ep_tready_o[i] && src_q[i].size() > 0)
        void'(src_q[i].pop_front());
    if (tx_tvalid_o && tx_tready_i) begin
      cap_q.push_back({tx_tlast_o, tx_tdata_o});
      if (tx_tlast_o) got_last = 1'b1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, got %0d checks", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic push_msg(input int idx, input int len);
    logic [8:0] e;
    for (int k = 0; k < len; k++) begin
      e = {k == len - 1, 8'($urandom)};
      src_q[idx].push_back(e);
      mq[idx].push_back(e);
    end
  endtask

  // expected answer to one IN: header, payload, zlp bookkeeping
  task automatic model_in(input int idx, input bit hs,
                          output logic [3:0] pid, output bit zlp,
                          output bit nak);
    int m;
    logic [8:0] e;
    m = hs ? 512 : 64;
    exp_q.delete();
    nak = 1'b0;
    zlp = 1'b0;
    pid = m_tgl[idx] ? 4'b1011 : 4'b0011;
    if (m_zlp[idx]) begin
      zlp = 1'b1;
      m_zlp[idx] = 1'b0;
    end else if (mq[idx].size() == 0) begin
      nak = 1'b1;
      pid = 4'b1010;
    end else begin
      while (exp_q.size() < m && mq[idx].size() > 0) begin
        e = mq[idx].pop_front();
        if (exp_q.size() == m - 1) begin
          m_zlp[idx] = e[8];
          e[8] = 1'b1;
        end
        exp_q.push_back(e);
        if (e[8]) break;
      end
    end
  endtask

  task automatic model_hs(input int idx, input bit nak, input bit ack);
    if (!nak && ack) m_tgl[idx] = ~m_tgl[idx];
  endtask

  task automatic pulse_clr(input int idx);
    @(negedge clock);
    clr_toggle_i = NUM_EP'(1) << idx;
    @(negedge clock);
    clr_toggle_i = '0;
    m_tgl[idx] = 1'b0;
    m_zlp[idx] = 1'b0;
  endtask

  // drives one IN transaction and reports what the DUT did
  task automatic run_in(input int ep, input bit hs, input bit ack,
                        output bit seen, output logic [3:0] pid,
                        output bit zlp, output logic [NUM_EP-1:0] xfer,
                        output bit tmo);
    int n;
    cap_q.delete();
    got_last = 1'b0;
    tmo = 1'b0;
    @(negedge clock);
    tok_valid_i = 1'b1;
    tok_ep_i = ep[3:0];
    hs_mode_i = hs;
    @(negedge clock);
    tok_valid_i = 1'b0;
    #1;
    seen = hdr_valid_o;
    pid = hdr_pid_o;
    zlp = hdr_zlp_o;
    xfer = ep_xfer_o;
    if (!seen) begin
      repeat (3) @(negedge clock);
      return;
    end
    repeat ($urandom_range(2)) @(negedge clock);
    hdr_ready_i = 1'b1;
    @(negedge clock);
    hdr_ready_i = 1'b0;
    if (pid == 4'b1010) return;
    if (!zlp) begin
      n = 0;
      while (!got_last && n < 3000) begin
        @(negedge clock);
        n++;
      end
      tmo = !got_last;
    end
    if (ack) ack_i = 1'b1;
    else timeout_i = 1'b1;
    @(negedge clock);
    ack_i = 1'b0;
    timeout_i = 1'b0;
  endtask

  function automatic int pay_bad();
    int bad;
    bad = 0;
    for (int i = 0; i < cap_q.size(); i++)
      if (i >= exp_q.size() || cap_q[i] !== exp_q[i]) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    n_chk++;
    if ({hdr_valid_o, hdr_pid_o, hdr_zlp_o, ep_xfer_o, tx_tvalid_o,
         tx_tlast_o, ep_tready_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: hv=%b pid=%h xfer=%b tv=%b rdy=%b, want all 0",
               hdr_valid_o, hdr_pid_o, ep_xfer_o, tx_tvalid_o, ep_tready_o);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_nak();
    bit seen, zlp, nak, ezlp, tmo;
    logic [3:0] pid, epid;
    logic [NUM_EP-1:0] xfer;
    model_in(0, 1'b1, epid, ezlp, nak);
    run_in(1, 1'b1, 1'b1, seen, pid, zlp, xfer, tmo);
    model_hs(0, nak, 1'b1);
    n_chk++;
    if (!seen || pid !== epid) begin
      n_fail++;
      $display("FAIL nak_pid: seen=%b got %h want %h", seen, pid, epid);
    end
    n_chk++;
    if (xfer !== '0) begin
      n_fail++;
      $display("FAIL nak_xfer: got %b want 0", xfer);
    end
  endtask

  task automatic test_hs_short();
    bit seen, zlp, nak, ezlp, tmo;
    logic [3:0] pid, epid;
    logic [NUM_EP-1:0] xfer;
    push_msg(0, 10);
    model_in(0, 1'b1, epid, ezlp, nak);
    run_in(1, 1'b1, 1'b1, seen, pid, zlp, xfer, tmo);
    model_hs(0, nak, 1'b1);
    n_chk++;
    if (pid !== 4'b0011 || pid !== epid) begin
      n_fail++;
      $display("FAIL hs_first_pid: got %h want %h", pid, 4'b0011);
    end
    n_chk++;
    if (xfer !== 2'b01) begin
      n_fail++;
      $display("FAIL hs_xfer: got %b want 01", xfer);
    end
    n_chk++;
    if (cap_q.size() != 10 || pay_bad() != 0 || tmo) begin
      n_fail++;
      $display("FAIL hs_payload: got %0d beats (%0d bad) want 10",
               cap_q.size(), pay_bad());
    end
    push_msg(0, 5);
    model_in(0, 1'b1, epid, ezlp, nak);
    run_in(1, 1'b1, 1'b1, seen, pid, zlp, xfer, tmo);
    model_hs(0, nak, 1'b1);
    n_chk++;
    if (pid !== 4'b1011 || cap_q.size() != 5 || pay_bad() != 0) begin
      n_fail++;
      $display("FAIL hs_second: pid %h beats %0d want pid b beats 5",
               pid, cap_q.size());
    end
  endtask

  task automatic test_fs_split();
    bit seen, zlp, nak, ezlp, tmo;
    logic [3:0] pid, epid;
    logic [NUM_EP-1:0] xfer;
    int elen[2] = '{64, 36};
    logic [3:0] wpid[2] = '{4'b0011, 4'b1011};
    push_msg(1, 100);
    for (int p = 0; p < 2; p++) begin
      model_in(1, 1'b0, epid, ezlp, nak);
      run_in(2, 1'b0, 1'b1, seen, pid, zlp, xfer, tmo);
      model_hs(1, nak, 1'b1);
      n_chk++;
      if (pid !== wpid[p] || pid !== epid || zlp) begin
        n_fail++;
        $display("FAIL fs_split_pid%0d: got %h zlp %b want %h", p, pid, zlp, wpid[p]);
      end
      n_chk++;
      if (cap_q.size() != elen[p] || pay_bad() != 0 || tmo ||
          cap_q[cap_q.size()-1][8] !== 1'b1) begin
        n_fail++;
        $display("FAIL fs_split_len%0d: got %0d beats (%0d bad) want %0d",
                 p, cap_q.size(), pay_bad(), elen[p]);
      end
    end
  endtask

  task automatic test_fs_zlp();
    bit seen, zlp, nak, ezlp, tmo;
    logic [3:0] pid, epid;
    logic [NUM_EP-1:0] xfer;
    pulse_clr(0);
    push_msg(0, 64);
    model_in(0, 1'b0, epid, ezlp, nak);
    run_in(1, 1'b0, 1'b1, seen, pid, zlp, xfer, tmo);
    model_hs(0, nak, 1'b1);
    n_chk++;
    if (pid !== 4'b0011 || cap_q.size() != 64 || pay_bad() != 0) begin
      n_fail++;
      $display("FAIL zlp_full: pid %h beats %0d want 3 / 64", pid, cap_q.size());
    end
    model_in(0, 1'b0, epid, ezlp, nak);
    run_in(1, 1'b0, 1'b1, seen, pid, zlp, xfer, tmo);
    model_hs(0, nak, 1'b1);
    n_chk++;
    if (pid !== 4'b1011 || zlp !== 1'b1 || !ezlp) begin
      n_fail++;
      $display("FAIL zlp_hdr: pid %h zlp %b want b / 1", pid, zlp);
    end
    n_chk++;
    if (cap_q.size() != 0 || xfer !== 2'b01) begin
      n_fail++;
      $display("FAIL zlp_nobeats: beats %0d xfer %b want 0 / 01", cap_q.size(), xfer);
    end
    model_in(0, 1'b0, epid, ezlp, nak);
    run_in(1, 1'b0, 1'b1, seen, pid, zlp, xfer, tmo);
    model_hs(0, nak, 1'b1);
    n_chk++;
    if (pid !== 4'b1010) begin
      n_fail++;
      $display("FAIL zlp_once: got %h want a", pid);
    end
  endtask

  task automatic test_timeout_clr();
    bit seen, zlp, nak, ezlp, tmo;
    logic [3:0] pid, epid;
    logic [NUM_EP-1:0] xfer;
    pulse_clr(1);
    for (int r = 0; r < 3; r++) begin
      push_msg(1, 8);
      model_in(1, 1'b0, epid, ezlp, nak);
      run_in(2, 1'b0, r != 0, seen, pid, zlp, xfer, tmo);
      model_hs(1, nak, r != 0);
      n_chk++;
      if (pid !== epid || cap_q.size() != 8 || pay_bad() != 0) begin
        n_fail++;
        $display("FAIL tmo_round%0d: pid %h beats %0d want %h / 8",
                 r, pid, cap_q.size(), epid);
      end
    end
    pulse_clr(1);
    push_msg(1, 3);
    model_in(1, 1'b0, epid, ezlp, nak);
    run_in(2, 1'b0, 1'b1, seen, pid, zlp, xfer, tmo);
    model_hs(1, nak, 1'b1);
    n_chk++;
    if (pid !== 4'b0011) begin
      n_fail++;
      $display("FAIL clr_toggle: got %h want 3", pid);
    end
  endtask

  task automatic test_random();
    bit seen, zlp, nak, ezlp, tmo, ack, hs;
    logic [3:0] pid, epid;
    logic [NUM_EP-1:0] xfer, exfer;
    int idx;
    for (int it = 0; it < 14; it++) begin
      idx = $urandom_range(NUM_EP - 1);
      hs = $urandom_range(3) == 0;
      ack = $urandom_range(3) != 0;
      if ($urandom_range(5) == 0) pulse_clr(idx);
      if ($urandom_range(4) != 0) push_msg(idx, $urandom_range(150, 1));
      model_in(idx, hs, epid, ezlp, nak);
      exfer = nak ? '0 : NUM_EP'(1) << idx;
      run_in(idx + EP_BASE, hs, ack, seen, pid, zlp, xfer, tmo);
      model_hs(idx, nak, ack);
      n_chk++;
      if (pid !== epid || zlp !== ezlp || xfer !== exfer) begin
        n_fail++;
        $display("FAIL rand_hdr%0d: pid %h zlp %b xfer %b want %h %b %b",
                 it, pid, zlp, xfer, epid, ezlp, exfer);
      end
      n_chk++;
      if (cap_q.size() != exp_q.size() || pay_bad() != 0 || tmo) begin
        n_fail++;
        $display("FAIL rand_pay%0d: beats %0d (%0d bad) want %0d",
                 it, cap_q.size(), pay_bad(), exp_q.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen, zlp, nak, ezlp, tmo;
    logic [3:0] pid, epid;
    logic [NUM_EP-1:0] xfer;
    push_msg(1, 200);
    @(negedge clock);
    tok_valid_i = 1'b1;
    tok_ep_i = 4'd2;
    hs_mode_i = 1'b1;
    @(negedge clock);
    tok_valid_i = 1'b0;
    hdr_ready_i = 1'b1;
    @(negedge clock);
    hdr_ready_i = 1'b0;
    repeat (4) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({hdr_valid_o, hdr_pid_o, ep_xfer_o, tx_tvalid_o, tx_tlast_o,
         ep_tready_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: hv=%b pid=%h xfer=%b tv=%b rdy=%b want 0",
               hdr_valid_o, hdr_pid_o, ep_xfer_o, tx_tvalid_o, ep_tready_o);
    end
    for (int i = 0; i < NUM_EP; i++) begin
      src_q[i].delete();
      mq[i].delete();
      m_tgl[i] = 1'b0;
      m_zlp[i] = 1'b0;
    end
    @(negedge clock);
    reset_n = 1'b1;
    model_in(0, 1'b0, epid, ezlp, nak);
    run_in(1, 1'b0, 1'b1, seen, pid, zlp, xfer, tmo);
    model_hs(0, nak, 1'b1);
    n_chk++;
    if (pid !== 4'b1010 || pid !== epid) begin
      n_fail++;
      $display("FAIL post_reset_nak: got %h want a", pid);
    end
    push_msg(1, 3);
    model_in(1, 1'b0, epid, ezlp, nak);
    run_in(2, 1'b0, 1'b1, seen, pid, zlp, xfer, tmo);
    model_hs(1, nak, 1'b1);
    n_chk++;
    if (pid !== 4'b0011 || cap_q.size() != 3 || pay_bad() != 0) begin
      n_fail++;
      $display("FAIL post_reset_data0: pid %h beats %0d want 3 / 3", pid, cap_q.size());
    end
    run_in(7, 1'b0, 1'b1, seen, pid, zlp, xfer, tmo);
    n_chk++;
    if (seen || hdr_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ep7_ignored: hdr_valid %b/%b want 0", seen, hdr_valid_o);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset_n = 1'b0;
    hs_mode_i = 1'b0;
    tok_valid_i = 1'b0;
    tok_ep_i = 4'd0;
    ack_i = 1'b0;
    timeout_i = 1'b0;
    clr_toggle_i = '0;
    hdr_ready_i = 1'b0;
    for (int i = 0; i < NUM_EP; i++) begin
      m_tgl[i] = 1'b0;
      m_zlp[i] = 1'b0;
    end
    test_reset();
    test_nak();
    test_hs_short();
    test_fs_split();
    test_fs_zlp();
    test_timeout_clr();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
